// File: rtl/chacha20_pkg.sv
// ChaCha20 block controller shared definitions.
// Sigma constants, round counts, quarter-round index tables and FSM states.
package chacha20_pkg;

    localparam int WORD_W       = 32;
    localparam int N_WORDS      = 16;
    localparam int N_ROUNDS     = 20;
    localparam int QR_PER_ROUND = 4;

    localparam logic [31:0] SIGMA [4] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
    };

    localparam logic [3:0] COL_IDX [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };

    localparam logic [3:0] DIAG_IDX [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        ADD,
        DONE
    } ctrl_state_t;

    // Odd rounds walk the diagonals, even rounds the columns.
    function automatic logic [3:0] qr_index(
        input logic       odd,
        input logic [1:0] grp,
        input logic [1:0] lane
    );
        return odd ? DIAG_IDX[grp][lane] : COL_IDX[grp][lane];
    endfunction

endpackage

// File: rtl/chacha20_block_ctrl_if.sv
// Quarter-round engine link between the block controller and the engine.
// master = controller side, slave = engine side.
interface chacha20_block_ctrl_if #(
    parameter int DATA_WIDTH = 32
);

    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] op_c;
    logic [DATA_WIDTH-1:0] op_d;
    logic                  op_valid;
    logic [DATA_WIDTH-1:0] res_a;
    logic [DATA_WIDTH-1:0] res_b;
    logic [DATA_WIDTH-1:0] res_c;
    logic [DATA_WIDTH-1:0] res_d;
    logic                  res_valid;
    logic                  busy;

    modport master (
        output op_a, op_b, op_c, op_d, op_valid,
        input  res_a, res_b, res_c, res_d, res_valid, busy
    );

    modport slave (
        input  op_a, op_b, op_c, op_d, op_valid,
        output res_a, res_b, res_c, res_d, res_valid, busy
    );

endinterface

// File: rtl/chacha20_block_ctrl.sv
// ChaCha20 block sequencer: loads the state, drives 80 quarter-rounds
// through an external engine, then adds the input state and emits a block.
module chacha20_block_ctrl
    import chacha20_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                       i_aclk,
    input  logic                       i_aresetn,
    input  logic [8*DATA_WIDTH-1:0]    i_key,
    input  logic [3*DATA_WIDTH-1:0]    i_nonce,
    input  logic [DATA_WIDTH-1:0]      i_counter,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic [16*DATA_WIDTH-1:0]   o_keystream,
    output logic                       o_valid,
    output logic [DATA_WIDTH-1:0]      o_qr_a,
    output logic [DATA_WIDTH-1:0]      o_qr_b,
    output logic [DATA_WIDTH-1:0]      o_qr_c,
    output logic [DATA_WIDTH-1:0]      o_qr_d,
    output logic                       o_qr_valid,
    input  logic [DATA_WIDTH-1:0]      i_qr_a,
    input  logic [DATA_WIDTH-1:0]      i_qr_b,
    input  logic [DATA_WIDTH-1:0]      i_qr_c,
    input  logic [DATA_WIDTH-1:0]      i_qr_d,
    input  logic                       i_qr_valid,
    input  logic                       i_qr_busy
);

    ctrl_state_t           state;
    logic [4:0]            rnd;
    logic [1:0]            qr_n;
    logic [DATA_WIDTH-1:0] x    [N_WORDS];
    logic [DATA_WIDTH-1:0] s    [N_WORDS];
    logic [DATA_WIDTH-1:0] init [N_WORDS];
    logic [3:0]            ia;
    logic [3:0]            ib;
    logic [3:0]            ic;
    logic [3:0]            id;
    logic                  last_qr;

    // Initial ChaCha state assembled from constants and the block inputs.
    always_comb begin
        for (int i = 0; i < N_WORDS; i++) begin
            init[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            init[i] = SIGMA[i];
        end
        for (int k = 0; k < 8; k++) begin
            init[4+k] = i_key[DATA_WIDTH*k +: DATA_WIDTH];
        end
        init[12] = i_counter;
        for (int n = 0; n < 3; n++) begin
            init[13+n] = i_nonce[DATA_WIDTH*n +: DATA_WIDTH];
        end
    end

    // Word indices of the quarter-round currently in flight.
    always_comb begin
        ia      = qr_index(rnd[0], qr_n, 2'd0);
        ib      = qr_index(rnd[0], qr_n, 2'd1);
        ic      = qr_index(rnd[0], qr_n, 2'd2);
        id      = qr_index(rnd[0], qr_n, 2'd3);
        last_qr = (rnd == 5'(N_ROUNDS - 1))
               && (qr_n == 2'(QR_PER_ROUND - 1));
    end

    // The strobe follows engine busy in the same cycle, so a stalled
    // ISSUE never presents a transaction and WAIT never presents one.
    assign o_qr_a     = x[ia];
    assign o_qr_b     = x[ib];
    assign o_qr_c     = x[ic];
    assign o_qr_d     = x[id];
    assign o_qr_valid = (state == ISSUE) && !i_qr_busy;

    // Block sequencing FSM with working state, copy and registered outputs.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state       <= IDLE;
            rnd         <= '0;
            qr_n        <= '0;
            o_busy      <= 1'b0;
            o_valid     <= 1'b0;
            o_keystream <= '0;
            for (int i = 0; i < N_WORDS; i++) begin
                x[i] <= '0;
                s[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= LOAD;
                        o_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < N_WORDS; i++) begin
                        x[i] <= init[i];
                        s[i] <= init[i];
                    end
                    rnd   <= '0;
                    qr_n  <= '0;
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (!i_qr_busy) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_qr_valid) begin
                        x[ia] <= i_qr_a;
                        x[ib] <= i_qr_b;
                        x[ic] <= i_qr_c;
                        x[id] <= i_qr_d;
                        if (last_qr) begin
                            rnd   <= '0;
                            qr_n  <= '0;
                            state <= ADD;
                        end else begin
                            qr_n  <= qr_n + 2'd1;
                            if (qr_n == 2'(QR_PER_ROUND - 1)) begin
                                rnd <= rnd + 5'd1;
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ADD: begin
                    for (int w = 0; w < N_WORDS; w++) begin
                        o_keystream[DATA_WIDTH*w +: DATA_WIDTH] <= x[w] + s[w];
                    end
                    o_valid <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
